// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-requester arbiter.
package arb_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ID_W    = 2;

   typedef enum logic [1:0] {IDLE, GRANT, BLOCK} arb_state_e;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
      onehot     = '0;
      onehot[id] = 1'b1;
   endfunction

endpackage

// File: rtl/req_arbiter4_if.sv
// Request/grant bundle between the masters and the arbiter.
interface req_arbiter4_if;
   import arb_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic               rr_en;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_valid;
   logic               timeout;

   modport master (
      output req,
      output rr_en,
      input  gnt,
      input  gnt_id,
      input  gnt_valid,
      input  timeout
   );

   modport slave (
      input  req,
      input  rr_en,
      output gnt,
      output gnt_id,
      output gnt_valid,
      output timeout
   );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection: fixed priority (highest index) or round-robin from rr_ptr,
// with one requester optionally masked out.
module arb_pick
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               mask_en,
   input  logic [ID_W-1:0]    mask_id,
   input  logic [ID_W-1:0]    rr_ptr,
   input  logic               rr_en,
   output logic [ID_W-1:0]    win_id,
   output logic               found
);

   logic [NUM_REQ-1:0] elig;

   always_comb begin
      elig   = req & ~(mask_en ? onehot(mask_id) : '0);
      found  = |elig;
      win_id = '0;
      if (rr_en) begin
         // Scan backwards so the candidate closest to rr_ptr is assigned last.
         for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (elig[rr_ptr + ID_W'(k)]) win_id = rr_ptr + ID_W'(k);
         end
      end else begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (elig[i]) win_id = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/req_arbiter4.sv
// 4-requester arbiter with hold-while-requesting, hold timeout and registered one-hot grants.
module req_arbiter4
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input logic           clk,
   input logic           rst_n,
   req_arbiter4_if.slave bus
);

   localparam bit TIMEOUT_EN = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

   arb_state_e         state;
   logic [NUM_REQ-1:0] gnt_q;
   logic [ID_W-1:0]    gnt_id_q;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    mask_id;
   logic [CNT_W-1:0]   hold_cnt;
   logic               timeout_q;

   logic               mask_en;
   logic [ID_W-1:0]    win_id;
   logic               found;

   assign mask_en = (state == BLOCK);

   arb_pick u_pick (
      .req     (bus.req),
      .mask_en (mask_en),
      .mask_id (mask_id),
      .rr_ptr  (rr_ptr),
      .rr_en   (bus.rr_en),
      .win_id  (win_id),
      .found   (found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         rr_ptr    <= '0;
         mask_id   <= '0;
         hold_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         unique case (state)
            IDLE: begin
               hold_cnt <= '0;
               if (found) begin
                  gnt_q    <= onehot(win_id);
                  gnt_id_q <= win_id;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               // Release wins over a coincident timeout.
               if (!bus.req[gnt_id_q]) begin
                  gnt_q    <= '0;
                  rr_ptr   <= gnt_id_q + ID_W'(1);
                  hold_cnt <= '0;
                  state    <= IDLE;
               end else if (TIMEOUT_EN && (hold_cnt == HOLD_LAST)) begin
                  gnt_q     <= '0;
                  timeout_q <= 1'b1;
                  mask_id   <= gnt_id_q;
                  rr_ptr    <= gnt_id_q + ID_W'(1);
                  hold_cnt  <= '0;
                  state     <= BLOCK;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            BLOCK: begin
               hold_cnt <= '0;
               if (found) begin
                  gnt_q    <= onehot(win_id);
                  gnt_id_q <= win_id;
                  state    <= GRANT;
               end else if (bus.req[mask_id]) begin
                  // Timed-out owner is the only requester left: hand it back.
                  gnt_q    <= onehot(mask_id);
                  gnt_id_q <= mask_id;
                  state    <= GRANT;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               gnt_q <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.gnt_valid = |gnt_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter4.sv
// Directed bench for req_arbiter4 (MAX_HOLD = 4) with a queue of expected grant outcomes.
module tb_req_arbiter4;

   typedef struct {
      logic [3:0] gnt;
      logic       tmo;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   req_arbiter4_if bus ();

   req_arbiter4 #(
      .MAX_HOLD (4),
      .CNT_W    (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] enc(input logic [3:0] g);
      case (g)
         4'b0010: enc = 2'd1;
         4'b0100: enc = 2'd2;
         4'b1000: enc = 2'd3;
         default: enc = 2'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic check_outputs();
      exp_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL scoreboard: observed empty queue expected entry");
         return;
      end
      e = exp_q.pop_front();
      check({e.tag, "/gnt"}, bus.gnt, e.gnt);
      check({e.tag, "/valid"}, {3'b0, bus.gnt_valid}, {3'b0, |e.gnt});
      check({e.tag, "/timeout"}, {3'b0, bus.timeout}, {3'b0, e.tmo});
      if (e.gnt != 4'b0) check({e.tag, "/gnt_id"}, {2'b0, bus.gnt_id}, {2'b0, enc(e.gnt)});
   endtask

   task automatic step(input logic [3:0] r, input logic rr, input logic [3:0] eg,
                       input logic et, input string tag);
      exp_t e;
      @(negedge clk);
      bus.req   = r;
      bus.rr_en = rr;
      e.gnt = eg;
      e.tmo = et;
      e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      exp_t e;
      bus.req   = 4'b0;
      bus.rr_en = 1'b0;
      #12;
      check("reset/gnt", bus.gnt, 4'b0);
      check("reset/gnt_id", {2'b0, bus.gnt_id}, 4'b0);
      check("reset/valid", {3'b0, bus.gnt_valid}, 4'b0);
      check("reset/timeout", {3'b0, bus.timeout}, 4'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "idle");

      // Round-robin from rr_ptr = 0, each owner holds two cycles then drops its bit.
      for (int i = 0; i < 5; i++) begin
         logic [3:0] own;
         own = 4'b0001 << (i % 4);
         step(4'b1111, 1'b1, own, 1'b0, "rr_grant");
         step(4'b1111, 1'b1, own, 1'b0, "rr_hold");
         step(4'b1111 & ~own, 1'b1, 4'b0000, 1'b0, "rr_dead");
      end
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "rr_idle");

      // Asynchronous reset in the middle of a grant.
      step(4'b1000, 1'b0, 4'b1000, 1'b0, "pre_rst_grant");
      step(4'b1000, 1'b0, 4'b1000, 1'b0, "pre_rst_hold");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async/gnt", bus.gnt, 4'b0);
      check("rst_async/valid", {3'b0, bus.gnt_valid}, 4'b0);
      check("rst_async/timeout", {3'b0, bus.timeout}, 4'b0);
      @(negedge clk);
      rst_n = 1'b1;
      e.gnt = 4'b1000;
      e.tmo = 1'b0;
      e.tag = "post_rst_grant";
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_outputs();
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "post_rst_release");

      // Fixed priority.
      step(4'b0110, 1'b0, 4'b0100, 1'b0, "fix_grant2");
      step(4'b0110, 1'b0, 4'b0100, 1'b0, "fix_hold2");
      step(4'b0010, 1'b0, 4'b0000, 1'b0, "fix_dead");
      step(4'b0010, 1'b0, 4'b0010, 1'b0, "fix_grant1");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "fix_release");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "fix_idle");

      // Timeout with a competing requester.
      for (int i = 0; i < 4; i++) step(4'b0011, 1'b0, 4'b0010, 1'b0, "to_hold");
      step(4'b0011, 1'b0, 4'b0000, 1'b1, "to_pulse");
      step(4'b0011, 1'b0, 4'b0001, 1'b0, "to_next");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "to_release");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "to_idle");

      // Sole requester timeout: regranted after the blocked cycle.
      for (int i = 0; i < 4; i++) step(4'b0100, 1'b0, 4'b0100, 1'b0, "sole_hold");
      step(4'b0100, 1'b0, 4'b0000, 1'b1, "sole_pulse");
      step(4'b0100, 1'b0, 4'b0100, 1'b0, "sole_regrant");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "sole_release");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "sole_idle");

      // Release coincident with the timeout condition: no pulse.
      for (int i = 0; i < 4; i++) step(4'b0100, 1'b0, 4'b0100, 1'b0, "coinc_hold");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "coinc_release");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "coinc_idle");

      // No preemption by a higher-priority arrival.
      step(4'b0001, 1'b0, 4'b0001, 1'b0, "np_grant0");
      step(4'b1001, 1'b0, 4'b0001, 1'b0, "np_hold0a");
      step(4'b1001, 1'b0, 4'b0001, 1'b0, "np_hold0b");
      step(4'b1000, 1'b0, 4'b0000, 1'b0, "np_dead");
      step(4'b1000, 1'b0, 4'b1000, 1'b0, "np_grant3");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "np_release");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "np_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/req_arbiter4.md
Name: req_arbiter4

Overview:
- Sequential 4-requester arbiter that shares one downstream resource, such as a bus or an execution unit.
- Arbitrates between fixed priority (request 3 highest, the same order as the team's 4-to-2 priority encoding) and round-robin, selected at run time.
- Holds a grant while the owner keeps requesting, up to a hold limit.
- Issues registered one-hot and encoded grants; sits between requesting masters and the shared datapath.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles for one owner; 0 disables the timeout.
- CNT_W, 5: hold counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; one clock domain, all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector, level-sensitive; req[i] high while master i wants the resource.
- rr_en  input  1  1 = round-robin, 0 = fixed priority; sampled only in arbitration cycles.
- gnt  output  4  one-hot grant, registered; all zero when no grant.
- gnt_id  output  2  encoded index of the owner; valid only when gnt_valid = 1.
- gnt_valid  output  1  high exactly when gnt is non-zero.
- timeout  output  1  one-cycle pulse when the owner is forcibly released.

Behaviour:
- Reset (async assert, sync release): gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0, state = IDLE, rr_ptr = 0, hold_cnt = 0, mask_id = 0.
- States: IDLE, GRANT, BLOCK.
- Winner selection:
  - Fixed priority: highest set index of the eligible requests.
  - Round-robin: first set index scanning rr_ptr, rr_ptr+1, … modulo 4.
- IDLE:
  - If req is non-zero, the winner is registered and the block moves to GRANT. Latency is 1 cycle from req sampled to gnt asserted.
  - hold_cnt is cleared to 0.
- GRANT, owner still requesting (req[gnt_id] = 1):
  - Grant holds and hold_cnt increments.
  - Other requests are ignored (no preemption, even in fixed-priority mode).
- GRANT, owner releases (req[gnt_id] = 0):
  - Next cycle gnt = 0 and the block returns to IDLE, giving at least one dead cycle between grants.
  - rr_ptr = gnt_id + 1 modulo 4, wrapping 3 to 0.
- GRANT, timeout (MAX_HOLD > 0, req[gnt_id] = 1, hold_cnt = MAX_HOLD - 1):
  - Next cycle gnt = 0 and timeout = 1 for that one cycle.
  - mask_id = gnt_id, rr_ptr = gnt_id + 1 modulo 4, state = BLOCK.
  - The owner holds the grant for exactly MAX_HOLD cycles.
- BLOCK (one cycle, gnt = 0):
  - Arbitrate over req with bit mask_id cleared.
  - If that is empty but req[mask_id] = 1, regrant mask_id with hold_cnt cleared.
  - If req = 0, go to IDLE. Otherwise go to GRANT.
- Simultaneous events:
  - A release and a timeout condition in the same cycle are treated as a release; no timeout pulse.
  - A request arriving in a dead cycle (IDLE or BLOCK) competes normally.
- Changing rr_en during GRANT has no effect until the next arbitration cycle.
- MAX_HOLD = 0: the timeout path is never taken and hold_cnt saturates at its maximum.
- Reset mid-grant: every output goes to its reset value immediately, with no clock required.
- Invariant: gnt is zero or one-hot at all times, and gnt_valid = |gnt.

Decomposition:
- Package arb_pkg:
  - NUM_REQ = 4, ID_W = 2.
  - State enum {IDLE, GRANT, BLOCK}.
  - Function onehot(id) returning a 4-bit vector.
- One combinational sub-module, arb_pick:
  - Inputs: req[3:0], mask_en, mask_id, rr_ptr, rr_en.
  - Outputs: win_id[1:0], found.
  - Instantiated once for the IDLE and BLOCK arbitration paths.

Test Plan:
- Reset: assert rst_n = 0 mid-grant with req = 4'b1000 → gnt = 0, gnt_valid = 0, timeout = 0 asynchronously; after release with req still high, gnt = 4'b1000 one cycle later.
- Fixed priority: rr_en = 0, req = 4'b0110 → gnt = 4'b0100, gnt_id = 2; drop req[2] → gnt = 0 for one cycle, then gnt = 4'b0010.
- Round-robin fairness: rr_en = 1, req = 4'b1111, each owner releases after 2 cycles → grant order 0, 1, 2, 3, 0 with one dead cycle between grants.
- Timeout: MAX_HOLD = 4, req = 4'b0011 held, rr_en = 0 → gnt = 4'b0010 for exactly 4 cycles, then timeout = 1 with gnt = 0, then gnt = 4'b0001.
- Sole requester timeout: MAX_HOLD = 4, req = 4'b0100 only → 4 grant cycles, one BLOCK cycle with timeout = 1, then gnt = 4'b0100 again.
- No preemption: owner 0 granted in fixed mode, req[3] rises → gnt stays 4'b0001 until req[0] drops, then gnt = 4'b1000 after the dead cycle.
